// File: rtl/elevator_pkg.sv
// -----------------------------------------------------------------------------
// elevator_pkg
//   Shared types and helpers for the 3-floor elevator controller.
//   - state_t      : controller state (2 bits)
//   - floor_t      : floor encoding FLOOR_1..FLOOR_3 (2 bits)
//   - req_t        : one bit per floor, bit 0 = floor 1
//   - DOOR_TICKS   : slow-clock ticks the door stays open
//   - TRAVEL_TICKS : slow-clock ticks to travel one floor
//   - helpers      : floor one-hot decode and travel-direction selection
// -----------------------------------------------------------------------------
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DOOR_OPEN = 2'd1,
        MOVING    = 2'd2,
        EMERGENCY = 2'd3
    } state_t;

    typedef logic [1:0] floor_t;

    localparam floor_t FLOOR_1 = 2'd0;
    localparam floor_t FLOOR_2 = 2'd1;
    localparam floor_t FLOOR_3 = 2'd2;

    localparam int NUM_FLOORS = 3;

    typedef logic [NUM_FLOORS-1:0] req_t;

    localparam logic [1:0] DOOR_TICKS   = 2'd3;
    localparam logic [1:0] TRAVEL_TICKS = 2'd2;

    // One-hot mask of a floor, aligned with req_t bit positions.
    function automatic req_t floor_onehot(input floor_t floor);
        case (floor)
            FLOOR_1: return 3'b001;
            FLOOR_2: return 3'b010;
            FLOOR_3: return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Floors strictly above the given floor.
    function automatic req_t above_mask(input floor_t floor);
        case (floor)
            FLOOR_1: return 3'b110;
            FLOOR_2: return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Floors strictly below the given floor.
    function automatic req_t below_mask(input floor_t floor);
        case (floor)
            FLOOR_2: return 3'b001;
            FLOOR_3: return 3'b011;
            default: return 3'b000;
        endcase
    endfunction

    // Direction for the next leg: keep going while a request lies beyond
    // the car in the current direction, otherwise turn around. With no
    // request on either side the current direction is kept.
    function automatic logic pick_dir_up(input floor_t floor, input req_t req,
                                         input logic dir_up);
        logic above;
        logic below;
        above = |(req & above_mask(floor));
        below = |(req & below_mask(floor));
        if (dir_up) begin
            return above || !below;
        end
        return above && !below;
    endfunction

endpackage

// File: rtl/clk_divider.sv
// -----------------------------------------------------------------------------
// clk_divider
//   Divides CLK_50 down to a 50% duty slow clock with a period of
//   clk_frequency CLK_50 cycles, and emits a one-cycle tick in the CLK_50
//   cycle during which the slow clock is high for the first time.
//   Parameters:
//     clk_frequency : CLK_50 cycles per slow-clock period (even, >= 2)
//   Ports:
//     CLK_50 (in)  board clock
//     rst_n  (in)  synchronous active-low reset
//     clk    (out) divided clock, starts low after reset
//     tick   (out) high for the one CLK_50 cycle following each 0->1 of clk
// -----------------------------------------------------------------------------
module clk_divider #(
    parameter int clk_frequency = 50_000_000
) (
    input  logic CLK_50,
    input  logic rst_n,
    output logic clk,
    output logic tick
);

    localparam int HALF  = clk_frequency / 2;
    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             wrap;

    // NOTE: every signal written here gets a value before any condition so
    // no path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        wrap   = (cnt_q == CNT_MAX);
        cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
        clk_d  = wrap ? ~clk_q : clk_q;
        // Registered together with clk, so tick is high exactly while the
        // first CLK_50 cycle of each slow-clock high phase is in progress.
        tick_d = wrap & ~clk_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK_50) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign clk  = clk_q;
    assign tick = tick_q;

endmodule

// File: rtl/elevator_top.sv
// -----------------------------------------------------------------------------
// elevator_top
//   3-floor elevator controller. Everything runs on CLK_50; the state machine
//   only advances its timers on the one-cycle tick from the clock divider.
//   Parameters:
//     clk_frequency : CLK_50 cycles per slow-clock period (even, >= 2)
//   Inputs (all asynchronous, synchronized internally):
//     CLK_50, rst_n (synchronous, active-low)
//     sos_button, weight_sensor, st/nd/rd_floor_button
//   Outputs:
//     clk             divided slow clock
//     sos_led         emergency mode active
//     weight_led      car overloaded
//     emergency_led   slow clock gated by (sos | overload)
//     st/nd/rd_floor_led  one-hot current floor
//     door_status_led 1 = door open
// -----------------------------------------------------------------------------
module elevator_top
    import elevator_pkg::*;
#(
    parameter int clk_frequency = 50_000_000
) (
    input  logic CLK_50,
    input  logic rst_n,
    input  logic sos_button,
    input  logic weight_sensor,
    input  logic st_floor_button,
    input  logic nd_floor_button,
    input  logic rd_floor_button,
    output logic clk,
    output logic sos_led,
    output logic weight_led,
    output logic emergency_led,
    output logic st_floor_led,
    output logic nd_floor_led,
    output logic rd_floor_led,
    output logic door_status_led
);

    // ------------------------------------------------------------------
    // Slow clock and tick
    // ------------------------------------------------------------------
    logic slow_clk;
    logic tick;

    clk_divider #(
        .clk_frequency (clk_frequency)
    ) u_clk_div (
        .CLK_50 (CLK_50),
        .rst_n  (rst_n),
        .clk    (slow_clk),
        .tick   (tick)
    );

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    //   raw bit order: [4]=sos [3]=weight [2]=floor3 [1]=floor2 [0]=floor1
    // ------------------------------------------------------------------
    logic [4:0] raw_in;
    logic [4:0] sync1_q, sync2_q;
    logic [3:0] btn_now;      // [3]=sos, [2:0]=floor buttons
    logic [3:0] btn_prev_q;
    logic [3:0] btn_edge;
    logic       sos_edge;
    req_t       floor_edge;
    logic       weight;

    assign raw_in     = {sos_button, weight_sensor, rd_floor_button,
                         nd_floor_button, st_floor_button};
    assign btn_now    = {sync2_q[4], sync2_q[2:0]};
    assign btn_edge   = btn_now & ~btn_prev_q;
    assign sos_edge   = btn_edge[3];
    assign floor_edge = btn_edge[2:0];
    assign weight     = sync2_q[3];

    // ------------------------------------------------------------------
    // Controller state
    // ------------------------------------------------------------------
    state_t     state_q, state_d;
    floor_t     floor_q, floor_d;
    logic [1:0] timer_q, timer_d;     // door-open or travel ticks elapsed
    logic       dir_up_q, dir_up_d;
    req_t       req_q, req_d;

    req_t       cur_mask;
    req_t       set_mask;
    req_t       req_n;
    req_t       arrive_mask;
    logic       door_open;
    logic       restart;

    assign cur_mask  = floor_onehot(floor_q);
    assign door_open = (state_q == IDLE) || (state_q == DOOR_OPEN);

    always_comb begin
        state_d     = state_q;
        floor_d     = floor_q;
        timer_d     = timer_q;
        dir_up_d    = dir_up_q;
        set_mask    = '0;
        req_n       = req_q;
        arrive_mask = '0;
        restart     = 1'b0;

        if (sos_edge) begin
            // SOS toggles emergency mode and wins over any floor button
            // edge in the same cycle; the car stays at floor_q.
            state_d = (state_q == EMERGENCY) ? IDLE : EMERGENCY;
            req_n   = '0;
            timer_d = '0;
        end else if (state_q == EMERGENCY) begin
            req_n = '0;
        end else begin
            set_mask = floor_edge;
            // Pressing the floor the car is standing at with the door open
            // keeps the door open longer rather than queuing a request.
            if (door_open && |(set_mask & cur_mask)) begin
                restart  = 1'b1;
                set_mask = set_mask & ~cur_mask;
            end
            req_n = req_q | set_mask;

            case (state_q)
                IDLE: begin
                    if (|req_n) begin
                        state_d = DOOR_OPEN;
                        timer_d = '0;
                    end
                end

                DOOR_OPEN: begin
                    if (restart) begin
                        timer_d = '0;
                    end else if (tick) begin
                        if (weight) begin
                            timer_d = '0;
                        end else if (timer_q == DOOR_TICKS - 2'd1) begin
                            timer_d = '0;
                            if (|req_n) begin
                                state_d  = MOVING;
                                dir_up_d = pick_dir_up(floor_q, req_n, dir_up_q);
                            end else begin
                                state_d = IDLE;
                            end
                        end else begin
                            timer_d = timer_q + 2'd1;
                        end
                    end
                end

                MOVING: begin
                    if (tick) begin
                        if (timer_q == TRAVEL_TICKS - 2'd1) begin
                            timer_d     = '0;
                            floor_d     = dir_up_q ? floor_q + 2'd1 : floor_q - 2'd1;
                            arrive_mask = floor_onehot(floor_d);
                            // Stop on a requested floor, when overloaded
                            // (travel to this floor is completed first), or
                            // when nothing else is left to serve.
                            if (|(req_n & arrive_mask) || weight ||
                                !(|(req_n & ~arrive_mask))) begin
                                req_n   = req_n & ~arrive_mask;
                                state_d = DOOR_OPEN;
                            end else begin
                                dir_up_d = pick_dir_up(floor_d, req_n, dir_up_q);
                            end
                        end else begin
                            timer_d = timer_q + 2'd1;
                        end
                    end
                end

                default: ;
            endcase
        end

        req_d = req_n;
    end

    always_ff @(posedge CLK_50) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            btn_prev_q <= '0;
            state_q    <= IDLE;
            floor_q    <= FLOOR_1;
            timer_q    <= '0;
            dir_up_q   <= 1'b1;
            req_q      <= '0;
        end else begin
            sync1_q    <= raw_in;
            sync2_q    <= sync1_q;
            btn_prev_q <= btn_now;
            state_q    <= state_d;
            floor_q    <= floor_d;
            timer_q    <= timer_d;
            dir_up_q   <= dir_up_d;
            req_q      <= req_d;
        end
    end

    // ------------------------------------------------------------------
    // LED decode
    // ------------------------------------------------------------------
    assign clk             = slow_clk;
    assign sos_led         = (state_q == EMERGENCY);
    assign weight_led      = weight;
    assign emergency_led   = slow_clk & (sos_led | weight);
    assign st_floor_led    = (floor_q == FLOOR_1);
    assign nd_floor_led    = (floor_q == FLOOR_2);
    assign rd_floor_led    = (floor_q == FLOOR_3);
    assign door_status_led = (state_q != MOVING);

endmodule

// File: tb/tb_elevator_top.sv
// -----------------------------------------------------------------------------
// tb_elevator_top
//   Directed scenarios followed by random button/weight/SOS activity. A
//   behavioural model of the controller (floors 1..3, per-floor request
//   flags, elapsed-tick counters) runs in lockstep with CLK_50 and predicts
//   every output each cycle.
// -----------------------------------------------------------------------------
module tb_elevator_top;

    localparam int CLK_FREQ = 4;
    localparam int HALF     = CLK_FREQ / 2;

    localparam int M_IDLE = 0;
    localparam int M_DOOR = 1;
    localparam int M_MOVE = 2;
    localparam int M_EMER = 3;

    logic CLK_50          = 1'b0;
    logic rst_n           = 1'b0;
    logic sos_button      = 1'b0;
    logic weight_sensor   = 1'b0;
    logic st_floor_button = 1'b0;
    logic nd_floor_button = 1'b0;
    logic rd_floor_button = 1'b0;

    logic clk;
    logic sos_led;
    logic weight_led;
    logic emergency_led;
    logic st_floor_led;
    logic nd_floor_led;
    logic rd_floor_led;
    logic door_status_led;

    elevator_top #(
        .clk_frequency (CLK_FREQ)
    ) u_dut (
        .CLK_50          (CLK_50),
        .rst_n           (rst_n),
        .sos_button      (sos_button),
        .weight_sensor   (weight_sensor),
        .st_floor_button (st_floor_button),
        .nd_floor_button (nd_floor_button),
        .rd_floor_button (rd_floor_button),
        .clk             (clk),
        .sos_led         (sos_led),
        .weight_led      (weight_led),
        .emergency_led   (emergency_led),
        .st_floor_led    (st_floor_led),
        .nd_floor_led    (nd_floor_led),
        .rd_floor_led    (rd_floor_led),
        .door_status_led (door_status_led)
    );

    always #5 CLK_50 = ~CLK_50;

    int tests_run    = 0;
    int tests_failed = 0;

    // ------------------------------------------------------------------
    // Reference model
    //   input bit order: [0]=sos [1]=weight [2]=floor1 [3]=floor2 [4]=floor3
    // ------------------------------------------------------------------
    int       m_k;          // CLK_50 edges since reset release
    bit [4:0] m_s1, m_s2, m_prev;
    int       m_mode;
    int       m_floor;      // 1..3
    int       m_age;        // ticks elapsed in the current door/travel phase
    bit [3:1] m_req;
    bit       m_up;

    task automatic model_reset();
        m_k     = 0;
        m_s1    = '0;
        m_s2    = '0;
        m_prev  = '0;
        m_mode  = M_IDLE;
        m_floor = 1;
        m_age   = 0;
        m_req   = '0;
        m_up    = 1'b1;
    endtask

    function automatic int req_count();
        int n = 0;
        for (int f = 1; f <= 3; f++) n += m_req[f];
        return n;
    endfunction

    function automatic bit choose_up();
        bit above = 1'b0;
        bit below = 1'b0;
        for (int f = 1; f <= 3; f++) begin
            if (m_req[f] && f > m_floor) above = 1'b1;
            if (m_req[f] && f < m_floor) below = 1'b1;
        end
        if (m_up && above)  return 1'b1;
        if (!m_up && below) return 1'b0;
        if (above)          return 1'b1;
        if (below)          return 1'b0;
        return m_up;
    endfunction

    // Called right after each CLK_50 rising edge; uses the inputs that
    // edge sampled and the model state from before the edge.
    task automatic model_clock();
        bit       tick_now;
        bit       w;
        bit       e_sos;
        bit       restart;
        bit       door_open;
        bit       hit;
        bit [4:0] inp;
        bit [4:0] edges;
        inp = {rd_floor_button, nd_floor_button, st_floor_button,
               weight_sensor, sos_button};
        if (!rst_n) begin
            model_reset();
            return;
        end
        tick_now = (m_k % CLK_FREQ) == HALF;
        w        = m_s2[1];
        edges    = m_s2 & ~m_prev;
        e_sos    = edges[0];

        if (e_sos) begin
            m_mode = (m_mode == M_EMER) ? M_IDLE : M_EMER;
            m_req  = '0;
            m_age  = 0;
        end else if (m_mode != M_EMER) begin
            door_open = (m_mode == M_IDLE) || (m_mode == M_DOOR);
            restart   = 1'b0;
            for (int f = 1; f <= 3; f++) begin
                if (edges[f+1]) begin
                    if (door_open && f == m_floor) restart = 1'b1;
                    else m_req[f] = 1'b1;
                end
            end
            case (m_mode)
                M_IDLE: begin
                    if (req_count() > 0) begin
                        m_mode = M_DOOR;
                        m_age  = 0;
                    end
                end
                M_DOOR: begin
                    if (restart) m_age = 0;
                    else if (tick_now) begin
                        if (w) m_age = 0;
                        else begin
                            m_age++;
                            if (m_age == 3) begin
                                m_age = 0;
                                if (req_count() > 0) begin
                                    m_mode = M_MOVE;
                                    m_up   = choose_up();
                                end else begin
                                    m_mode = M_IDLE;
                                end
                            end
                        end
                    end
                end
                M_MOVE: begin
                    if (tick_now) begin
                        m_age++;
                        if (m_age == 2) begin
                            m_age   = 0;
                            m_floor = m_floor + (m_up ? 1 : -1);
                            hit     = m_req[m_floor];
                            if (hit || w || (req_count() - int'(hit)) == 0) begin
                                m_req[m_floor] = 1'b0;
                                m_mode         = M_DOOR;
                            end else begin
                                m_up = choose_up();
                            end
                        end
                    end
                end
                default: ;
            endcase
        end

        m_prev = m_s2;
        m_s2   = m_s1;
        m_s1   = inp;
        m_k++;
    endtask

    // {clk, tick, sos, weight, emergency, floor1, floor2, floor3, door}
    function automatic logic [8:0] model_outputs();
        bit mclk  = ((m_k / HALF) % 2) == 1;
        bit mtick = (m_k % CLK_FREQ) == HALF;
        bit memer = (m_mode == M_EMER);
        bit w     = m_s2[1];
        return {mclk, mtick, memer, w, mclk & (memer | w),
                m_floor == 1, m_floor == 2, m_floor == 3, m_mode != M_MOVE};
    endfunction

    function automatic logic [8:0] dut_outputs();
        return {clk, u_dut.tick, sos_led, weight_led, emergency_led,
                st_floor_led, nd_floor_led, rd_floor_led, door_status_led};
    endfunction

    task automatic check(input string tag, input logic [8:0] observed,
                         input logic [8:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic step(input string tag);
        @(posedge CLK_50);
        model_clock();
        @(negedge CLK_50);
        check(tag, dut_outputs(), model_outputs());
    endtask

    // Reset view of {clk, sos, weight, emergency, f1, f2, f3, door}.
    localparam logic [8:0] RESET_LEDS = 9'b0_0000_1001;

    function automatic logic [8:0] led_view();
        return {1'b0, clk, sos_led, weight_led, emergency_led,
                st_floor_led, nd_floor_led, rd_floor_led, door_status_led};
    endfunction

    int   n;
    int   rises;
    int   ticks;
    int   misaligned;
    logic prev_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();

        // ---- reset values --------------------------------------------
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) step("reset_hold");
        check("reset_leds", led_view(), RESET_LEDS);

        // ---- divider: 22 CLK_50 edges after release ------------------
        rst_n      = 1'b1;
        rises      = 0;
        ticks      = 0;
        misaligned = 0;
        prev_clk   = 1'b0;
        for (int i = 0; i < 22; i++) begin
            step("divider");
            if (clk && !prev_clk) rises++;
            if (u_dut.tick) ticks++;
            if (u_dut.tick !== (clk && !prev_clk)) misaligned++;
            prev_clk = clk;
        end
        // clk rises at edges 2, 6, 10, 14, 18, 22 after release
        check("clk_rises", 9'(rises), 9'd6);
        check("tick_count", 9'(ticks), 9'd6);
        check("tick_align", 9'(misaligned), 9'd0);

        // ---- trip from floor 1 to floor 3 ----------------------------
        rd_floor_button = 1'b1;
        for (int i = 0; i < 3; i++) step("press_f3");
        rd_floor_button = 1'b0;
        n = 0;
        while (!(rd_floor_led && door_status_led) && n < 200) begin
            step("trip_f3");
            n++;
        end
        check("trip_f3_arrive", {8'd0, n < 200}, 9'd1);
        check("trip_f3_leds", {5'd0, st_floor_led, nd_floor_led, rd_floor_led,
                               door_status_led}, 9'b0_0000_0011);

        // ---- overload with a pending request -------------------------
        st_floor_button = 1'b1;
        weight_sensor   = 1'b1;
        for (int i = 0; i < 2; i++) step("press_f1_heavy");
        st_floor_button = 1'b0;
        for (int i = 0; i < 60; i++) step("overload_hold");
        check("overload_leds", {6'd0, weight_led, rd_floor_led, door_status_led},
              9'b0_0000_0111);
        weight_sensor = 1'b0;
        n = 0;
        while (door_status_led && n < 100) begin
            step("overload_release");
            n++;
        end
        check("overload_depart", {8'd0, n < 100}, 9'd1);

        // ---- SOS while moving ----------------------------------------
        sos_button = 1'b1;
        step("sos_press");
        sos_button = 1'b0;
        for (int i = 0; i < 4; i++) step("sos_enter");
        check("sos_enter_leds", {7'd0, sos_led, door_status_led}, 9'd3);
        nd_floor_button = 1'b1;
        step("sos_ignored_btn");
        nd_floor_button = 1'b0;
        for (int i = 0; i < 30; i++) step("sos_hold");
        check("sos_hold_leds", {7'd0, sos_led, door_status_led}, 9'd3);
        sos_button = 1'b1;
        step("sos_press2");
        sos_button = 1'b0;
        for (int i = 0; i < 4; i++) step("sos_exit");
        check("sos_exit_leds", {7'd0, sos_led, door_status_led}, 9'd1);
        for (int i = 0; i < 30; i++) step("after_sos_idle");
        check("after_sos_parked", {8'd0, door_status_led}, 9'd1);

        // ---- reset mid-travel ----------------------------------------
        st_floor_button = 1'b1;
        nd_floor_button = 1'b1;
        rd_floor_button = 1'b1;
        step("press_all");
        st_floor_button = 1'b0;
        nd_floor_button = 1'b0;
        rd_floor_button = 1'b0;
        n = 0;
        while (door_status_led && n < 100) begin
            step("wait_move");
            n++;
        end
        check("reset_trip_depart", {8'd0, n < 100}, 9'd1);
        for (int i = 0; i < 3; i++) step("mid_travel");
        rst_n = 1'b0;
        step("mid_reset");
        check("mid_reset_leds", led_view(), RESET_LEDS);
        rst_n = 1'b1;

        // ---- random activity -----------------------------------------
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 29) == 0) st_floor_button = ~st_floor_button;
            if ($urandom_range(0, 29) == 0) nd_floor_button = ~nd_floor_button;
            if ($urandom_range(0, 29) == 0) rd_floor_button = ~rd_floor_button;
            if (weight_sensor) begin
                if ($urandom_range(0, 39) == 0) weight_sensor = 1'b0;
            end else if ($urandom_range(0, 299) == 0) begin
                weight_sensor = 1'b1;
            end
            if (sos_button) sos_button = 1'b0;
            else if ($urandom_range(0, sos_led ? 59 : 799) == 0) sos_button = 1'b1;
            rst_n = ($urandom_range(0, 1999) != 0);
            step("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
